// File: rtl/int_timer_ctrl_if.sv
// Memory-mapped register bus between the load/store path (master) and int_timer_ctrl (slave).
// Read data is returned one cycle after reg_re and held until the next read.
interface int_timer_ctrl_if;
  logic        reg_we;
  logic        reg_re;
  logic [2:0]  reg_adr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;

  modport master (
    output reg_we,
    output reg_re,
    output reg_adr,
    output reg_wdata,
    input  reg_rdata
  );

  modport slave (
    input  reg_we,
    input  reg_re,
    input  reg_adr,
    input  reg_wdata,
    output reg_rdata
  );
endinterface

// File: rtl/int_timer_ctrl.sv
// Machine-level interrupt source: mtime/mtimecmp timer, msip bit, synchronised external pin, MEI>MSI>MTI arbitration.
// Optional macro INT_EXT_EDGE_EN turns meip into a sticky rising-edge latch cleared when the MEI trap is acknowledged.
module int_timer_ctrl #(
  parameter int unsigned TIMER_DIV = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  int_timer_ctrl_if.slave        bus,
  input  logic                   ext_int_in_i,
  input  logic                   csr_rmie_i,
  input  logic                   csr_meie_i,
  input  logic                   csr_mtie_i,
  input  logic                   csr_msie_i,
  input  logic                   int_ack_i,
  input  logic                   cmd_mret_ex_i,
  output logic                   g_interrupt_o,
  output logic [1:0]             g_interrupt_priv_o,
  output logic [5:0]             int_cause_o,
  output logic [2:0]             mip_bits_o
);

  localparam int unsigned   PW      = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TIMER_DIV - 1);

  localparam logic [2:0] ADR_MTIME_LO = 3'd0;
  localparam logic [2:0] ADR_MTIME_HI = 3'd1;
  localparam logic [2:0] ADR_CMP_LO   = 3'd2;
  localparam logic [2:0] ADR_CMP_HI   = 3'd3;
  localparam logic [2:0] ADR_MSIP     = 3'd4;

  localparam logic [5:0] CAUSE_NONE = 6'd0;
  localparam logic [5:0] CAUSE_MSI  = 6'd3;
  localparam logic [5:0] CAUSE_MTI  = 6'd7;
  localparam logic [5:0] CAUSE_MEI  = 6'd11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;
  logic [63:0]   mtime_q;
  logic [63:0]   mtime_d;
  logic [63:0]   cmp_q;
  logic [63:0]   cmp_d;
  logic          msip_q;
  logic          msip_d;
  logic          mtip_q;
  logic          sync1_q;
  logic          sync2_q;
  logic [31:0]   rdata_q;
  logic [31:0]   rdata_d;
  state_t        state_q;
  logic          g_int_q;
  logic [5:0]    cause_q;

  logic          tick_s;
  logic          mtime_wr_s;
  logic          meip_s;
  logic          p_e_s;
  logic          p_s_s;
  logic          p_t_s;
  logic          any_s;
  logic [5:0]    best_cause_s;

  // Prescaler, mtime, mtimecmp and msip next-state; a software write to mtime overrides the tick.
  always_comb begin
    tick_s     = (pre_q == PRE_MAX);
    mtime_wr_s = bus.reg_we && ((bus.reg_adr == ADR_MTIME_LO) || (bus.reg_adr == ADR_MTIME_HI));
    if (tick_s) begin
      pre_d = {PW{1'b0}};
    end else begin
      pre_d = pre_q + PW'(1);
    end
    if (mtime_wr_s) begin
      if (bus.reg_adr == ADR_MTIME_LO) begin
        mtime_d = {mtime_q[63:32], bus.reg_wdata};
      end else begin
        mtime_d = {bus.reg_wdata, mtime_q[31:0]};
      end
    end else if (tick_s) begin
      mtime_d = mtime_q + 64'd1;
    end else begin
      mtime_d = mtime_q;
    end
    if (bus.reg_we && (bus.reg_adr == ADR_CMP_LO)) begin
      cmp_d = {cmp_q[63:32], bus.reg_wdata};
    end else if (bus.reg_we && (bus.reg_adr == ADR_CMP_HI)) begin
      cmp_d = {bus.reg_wdata, cmp_q[31:0]};
    end else begin
      cmp_d = cmp_q;
    end
    if (bus.reg_we && (bus.reg_adr == ADR_MSIP)) begin
      msip_d = bus.reg_wdata[0];
    end else begin
      msip_d = msip_q;
    end
  end

  // Read mux samples pre-write state, so a same-cycle write to the read offset returns the old value.
  always_comb begin
    case (bus.reg_adr)
      ADR_MTIME_LO: rdata_d = mtime_q[31:0];
      ADR_MTIME_HI: rdata_d = mtime_q[63:32];
      ADR_CMP_LO:   rdata_d = cmp_q[31:0];
      ADR_CMP_HI:   rdata_d = cmp_q[63:32];
      ADR_MSIP:     rdata_d = {31'd0, msip_q};
      default:      rdata_d = 32'd0;
    endcase
  end

  // Timer, register file, pin synchroniser and read-data holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q   <= {PW{1'b0}};
      mtime_q <= 64'd0;
      cmp_q   <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q  <= 1'b0;
      mtip_q  <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      pre_q   <= pre_d;
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      msip_q  <= msip_d;
      mtip_q  <= (mtime_q >= cmp_q);
      sync1_q <= ext_int_in_i;
      sync2_q <= sync1_q;
      if (bus.reg_re) begin
        rdata_q <= rdata_d;
      end
    end
  end

`ifdef INT_EXT_EDGE_EN
  logic meip_q;
  logic ext_rise_s;
  logic meip_clr_s;

  assign ext_rise_s = sync1_q & ~sync2_q;
  assign meip_clr_s = (state_q == ST_REQ) & int_ack_i & (cause_q == CAUSE_MEI);

  // Sticky external pending: a new edge outranks the acknowledge clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meip_q <= 1'b0;
    end else if (ext_rise_s) begin
      meip_q <= 1'b1;
    end else if (meip_clr_s) begin
      meip_q <= 1'b0;
    end
  end

  assign meip_s = meip_q;
`else
  assign meip_s = sync2_q;
`endif

  // Masked pending sources and fixed-priority cause encoder.
  always_comb begin
    p_e_s = meip_s & csr_meie_i;
    p_s_s = msip_q & csr_msie_i;
    p_t_s = mtip_q & csr_mtie_i;
    any_s = p_e_s | p_s_s | p_t_s;
    if (p_e_s) begin
      best_cause_s = CAUSE_MEI;
    end else if (p_s_s) begin
      best_cause_s = CAUSE_MSI;
    end else if (p_t_s) begin
      best_cause_s = CAUSE_MTI;
    end else begin
      best_cause_s = CAUSE_NONE;
    end
  end

  // Request FSM: an ack in REQ outranks a simultaneous withdrawal and freezes the cause.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      g_int_q <= 1'b0;
      cause_q <= CAUSE_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (csr_rmie_i && any_s) begin
            state_q <= ST_REQ;
            g_int_q <= 1'b1;
            cause_q <= best_cause_s;
          end else begin
            g_int_q <= 1'b0;
            cause_q <= CAUSE_NONE;
          end
        end
        ST_REQ: begin
          if (int_ack_i) begin
            state_q <= ST_SERVICE;
            g_int_q <= 1'b0;
          end else if (!csr_rmie_i || !any_s) begin
            state_q <= ST_IDLE;
            g_int_q <= 1'b0;
            cause_q <= CAUSE_NONE;
          end else begin
            g_int_q <= 1'b1;
            cause_q <= best_cause_s;
          end
        end
        ST_SERVICE: begin
          g_int_q <= 1'b0;
          if (cmd_mret_ex_i) begin
            state_q <= ST_IDLE;
            cause_q <= CAUSE_NONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          g_int_q <= 1'b0;
          cause_q <= CAUSE_NONE;
        end
      endcase
    end
  end

  assign bus.reg_rdata      = rdata_q;
  assign g_interrupt_o      = g_int_q;
  assign g_interrupt_priv_o = 2'b11;
  assign int_cause_o        = cause_q;
  assign mip_bits_o         = {meip_s, mtip_q, msip_q};

endmodule
